// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch-stage PC generator.
//   - Exception codes raised by the fetch address check.
//   - Default reset / handler vectors and the legal fetch window.
//   - Exception-level state encoding (RUN / HANDLER).
package pc_gen_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] DEF_ADDR_LO     = 32'h0000_3000;
  localparam logic [31:0] DEF_ADDR_HI     = 32'h0000_4FFC;

  // The state value doubles as the exl flag.
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/pc_fault_check.sv
// pc_fault_check: combinational legality check of the current fetch PC.
//   pc       in  WIDTH : current PC register value
//   fault    out 1     : PC is misaligned (or out of range when enabled)
//   exc_code out 5     : EXC_ADEL when fault, else EXC_NONE
// Optional feature macro PC_BOUND_CHECK_EN: when defined, PCs outside
// [ADDR_LO, ADDR_HI] (unsigned) also fault; when undefined only alignment
// is checked and no comparators are built.
module pc_fault_check
  import pc_gen_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter int              ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] ADDR_LO   = WIDTH'(DEF_ADDR_LO),
  parameter logic [WIDTH-1:0] ADDR_HI   = WIDTH'(DEF_ADDR_HI)
) (
  input  logic [WIDTH-1:0] pc,
  output logic             fault,
  output logic [4:0]       exc_code
);

  logic misaligned;
  logic out_of_range;

  assign misaligned = (pc[ALIGN_BITS-1:0] != '0);

`ifdef PC_BOUND_CHECK_EN
  assign out_of_range = (pc < ADDR_LO) || (pc > ADDR_HI);
`else
  // Upper PC bits and the window bounds only matter to the range check.
  logic unused_range;
  assign unused_range = ^{pc[WIDTH-1:ALIGN_BITS], ADDR_LO, ADDR_HI};
  assign out_of_range = 1'b0;
`endif

  assign fault    = misaligned | out_of_range;
  assign exc_code = fault ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
// Owns the PC register, EPC and the exception-level flag, and reports
// whether the current PC is a legal fetch address.
//   clk            in  1     : rising-edge clock
//   reset          in  1     : asynchronous active-low reset
//   stall          in  1     : hold PC (sequential / redirect updates only)
//   redirect       in  1     : branch/jump taken
//   redirect_pc    in  WIDTH : branch/jump target
//   exc_req        in  1     : exception taken by a later stage
//   exc_pc         in  WIDTH : victim PC to save in EPC
//   eret           in  1     : return from exception
//   pc             out WIDTH : current fetch PC
//   pc_offset      out 16    : pc[15:0] - ADDR_LO[15:0] (imem index)
//   fetch_fault    out 1     : current PC is illegal
//   fetch_exc_code out 5     : EXC_ADEL on fault, else 0
//   epc            out WIDTH : saved return address
//   exl            out 1     : exception level (1 = in handler)
// Optional feature macro PC_BOUND_CHECK_EN enables the address range check
// inside pc_fault_check. WIDTH must be at least 16.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] HANDLER_VEC = WIDTH'(DEF_HANDLER_VEC),
  parameter logic [WIDTH-1:0] ADDR_LO     = WIDTH'(DEF_ADDR_LO),
  parameter logic [WIDTH-1:0] ADDR_HI     = WIDTH'(DEF_ADDR_HI),
  parameter int               ALIGN_BITS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [15:0]      pc_offset,
  output logic             fetch_fault,
  output logic [4:0]       fetch_exc_code,
  output logic [WIDTH-1:0] epc,
  output logic             exl
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1) << ALIGN_BITS;

  exc_state_e state;

  // Exception entry beats eret, and both beat stall; an eret outside the
  // handler is ignored and falls through to the normal update rules.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_VEC;
      epc   <= '0;
      state <= RUN;
    end else if (exc_req) begin
      pc <= HANDLER_VEC;
      // Nested exceptions keep the original return address.
      if (state == RUN) begin
        epc   <= exc_pc;
        state <= HANDLER;
      end
    end else if (eret && (state == HANDLER)) begin
      pc    <= epc;
      state <= RUN;
    end else if (stall) begin
      pc <= pc;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else begin
      pc <= pc + STEP;
    end
  end

  assign exl       = (state == HANDLER);
  assign pc_offset = pc[15:0] - ADDR_LO[15:0];

  pc_fault_check #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS),
    .ADDR_LO    (ADDR_LO),
    .ADDR_HI    (ADDR_HI)
  ) u_fault_check (
    .pc       (pc),
    .fault    (fetch_fault),
    .exc_code (fetch_exc_code)
  );

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif
  localparam logic [4:0] BCODE = BOUND ? 5'd4 : 5'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, exc_req, eret;
  logic [31:0] redirect_pc, exc_pc;
  logic [31:0] pc, epc;
  logic [15:0] pc_offset;
  logic        fetch_fault, exl;
  logic [4:0]  fetch_exc_code;

  // 16-bit instance used for the wrap-around scenario.
  logic        stall16, redirect16, exc_req16, eret16;
  logic [15:0] redirect_pc16, exc_pc16;
  logic [15:0] pc16, epc16, pc_offset16;
  logic        fault16, exl16;
  logic [4:0]  code16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret),
    .pc(pc), .pc_offset(pc_offset), .fetch_fault(fetch_fault),
    .fetch_exc_code(fetch_exc_code), .epc(epc), .exl(exl)
  );

  pc_gen #(
    .WIDTH(16), .RESET_VEC(16'hFFFC), .HANDLER_VEC(16'h4180),
    .ADDR_LO(16'h3000), .ADDR_HI(16'h4FFC), .ALIGN_BITS(2)
  ) dut16 (
    .clk(clk), .reset(reset), .stall(stall16), .redirect(redirect16),
    .redirect_pc(redirect_pc16), .exc_req(exc_req16), .exc_pc(exc_pc16), .eret(eret16),
    .pc(pc16), .pc_offset(pc_offset16), .fetch_fault(fault16),
    .fetch_exc_code(code16), .epc(epc16), .exl(exl16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 0; redirect = 0; exc_req = 0; eret = 0;
    redirect_pc = '0; exc_pc = '0;
    stall16 = 0; redirect16 = 0; exc_req16 = 0; eret16 = 0;
    redirect_pc16 = '0; exc_pc16 = '0;
    repeat (2) tick();
    checks++; if (pc !== 32'h3000 || epc !== 32'h0 || exl !== 1'b0)
      begin errors++; $display("FAIL reset_state: pc=%h epc=%h exl=%b want 3000 0 0", pc, epc, exl); end
    checks++; if (fetch_fault !== 1'b0 || fetch_exc_code !== 5'd0 || pc_offset !== 16'h0)
      begin errors++; $display("FAIL reset_fault: fault=%b code=%0d off=%h want 0 0 0", fetch_fault, fetch_exc_code, pc_offset); end
    checks++; if (pc16 !== 16'hFFFC || fault16 !== BOUND || code16 !== BCODE)
      begin errors++; $display("FAIL reset16: pc=%h fault=%b code=%0d want fffc %b %0d", pc16, fault16, code16, BOUND, BCODE); end
    reset = 1'b1;
    tick();
    checks++; if (pc !== 32'h3004)
      begin errors++; $display("FAIL seq1: pc=%h want 3004", pc); end
    checks++; if (pc16 !== 16'h0000 || fault16 !== BOUND || code16 !== BCODE)
      begin errors++; $display("FAIL wrap16: pc=%h fault=%b code=%0d want 0000 %b %0d", pc16, fault16, code16, BOUND, BCODE); end
    tick();
    checks++; if (pc !== 32'h3008)
      begin errors++; $display("FAIL seq2: pc=%h want 3008", pc); end
    tick();
    checks++; if (pc !== 32'h300C || pc_offset !== 16'h000C)
      begin errors++; $display("FAIL seq3: pc=%h off=%h want 300c 000c", pc, pc_offset); end
    reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h3000)
      begin errors++; $display("FAIL async_reset: pc=%h want 3000", pc); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_stall();
    tick();
    tick();
    checks++; if (pc !== 32'h3008)
      begin errors++; $display("FAIL pre_stall: pc=%h want 3008", pc); end
    stall = 1;
    tick();
    tick();
    checks++; if (pc !== 32'h3008)
      begin errors++; $display("FAIL stall_hold: pc=%h want 3008", pc); end
    redirect = 1; redirect_pc = 32'h3100;
    tick();
    checks++; if (pc !== 32'h3008)
      begin errors++; $display("FAIL redirect_under_stall: pc=%h want 3008", pc); end
    stall = 0;
    tick();
    checks++; if (pc !== 32'h3100)
      begin errors++; $display("FAIL redirect: pc=%h want 3100", pc); end
    redirect = 0;
  endtask

  task automatic test_exception();
    stall = 1; exc_req = 1; exc_pc = 32'h3010;
    tick();
    checks++; if (pc !== 32'h4180 || epc !== 32'h3010 || exl !== 1'b1)
      begin errors++; $display("FAIL exc_entry: pc=%h epc=%h exl=%b want 4180 3010 1", pc, epc, exl); end
    stall = 0; exc_pc = 32'h4184;
    tick();
    checks++; if (pc !== 32'h4180 || epc !== 32'h3010 || exl !== 1'b1)
      begin errors++; $display("FAIL exc_nested: pc=%h epc=%h exl=%b want 4180 3010 1", pc, epc, exl); end
    exc_req = 0;
    tick();
    checks++; if (pc !== 32'h4184 || exl !== 1'b1)
      begin errors++; $display("FAIL handler_seq: pc=%h exl=%b want 4184 1", pc, exl); end
    eret = 1;
    tick();
    checks++; if (pc !== 32'h3010 || exl !== 1'b0 || epc !== 32'h3010)
      begin errors++; $display("FAIL eret: pc=%h exl=%b epc=%h want 3010 0 3010", pc, exl, epc); end
    tick();
    checks++; if (pc !== 32'h3014 || exl !== 1'b0)
      begin errors++; $display("FAIL eret_in_run: pc=%h exl=%b want 3014 0", pc, exl); end
    exc_req = 1; exc_pc = 32'h3014;
    tick();
    checks++; if (pc !== 32'h4180 || exl !== 1'b1 || epc !== 32'h3014)
      begin errors++; $display("FAIL exc_beats_eret_run: pc=%h exl=%b epc=%h want 4180 1 3014", pc, exl, epc); end
    exc_pc = 32'h4180;
    tick();
    checks++; if (pc !== 32'h4180 || exl !== 1'b1 || epc !== 32'h3014)
      begin errors++; $display("FAIL exc_beats_eret_hdl: pc=%h exl=%b epc=%h want 4180 1 3014", pc, exl, epc); end
    exc_req = 0; eret = 0; stall = 1;
    tick();
    checks++; if (pc !== 32'h4180)
      begin errors++; $display("FAIL handler_stall: pc=%h want 4180", pc); end
    eret = 1;
    tick();
    checks++; if (pc !== 32'h3014 || exl !== 1'b0)
      begin errors++; $display("FAIL eret_over_stall: pc=%h exl=%b want 3014 0", pc, exl); end
    eret = 0; stall = 0;
    exc_req = 1; exc_pc = 32'h3020;
    tick();
    checks++; if (exl !== 1'b1 || epc !== 32'h3020)
      begin errors++; $display("FAIL exc_again: exl=%b epc=%h want 1 3020", exl, epc); end
    exc_req = 0; eret = 1;
    reset = 1'b0;
    #1;
    checks++; if (exl !== 1'b0 || pc !== 32'h3000 || epc !== 32'h0)
      begin errors++; $display("FAIL reset_in_handler: exl=%b pc=%h epc=%h want 0 3000 0", exl, pc, epc); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (pc !== 32'h3004 || exl !== 1'b0)
      begin errors++; $display("FAIL eret_lost: pc=%h exl=%b want 3004 0", pc, exl); end
    eret = 0;
  endtask

  task automatic test_fault();
    redirect = 1; redirect_pc = 32'h3002;
    tick();
    checks++; if (pc !== 32'h3002 || fetch_fault !== 1'b1 || fetch_exc_code !== 5'd4 || pc_offset !== 16'h0002)
      begin errors++; $display("FAIL misaligned: pc=%h fault=%b code=%0d off=%h want 3002 1 4 0002", pc, fetch_fault, fetch_exc_code, pc_offset); end
    redirect_pc = 32'h5000;
    tick();
    checks++; if (fetch_fault !== BOUND || fetch_exc_code !== BCODE || pc_offset !== 16'h2000)
      begin errors++; $display("FAIL above_hi: fault=%b code=%0d off=%h want %b %0d 2000", fetch_fault, fetch_exc_code, pc_offset, BOUND, BCODE); end
    redirect_pc = 32'h4FFC;
    tick();
    checks++; if (fetch_fault !== 1'b0 || fetch_exc_code !== 5'd0)
      begin errors++; $display("FAIL at_hi: fault=%b code=%0d want 0 0", fetch_fault, fetch_exc_code); end
    redirect_pc = 32'h2FFC;
    tick();
    checks++; if (fetch_fault !== BOUND || pc_offset !== 16'hFFFC)
      begin errors++; $display("FAIL below_lo: fault=%b off=%h want %b fffc", fetch_fault, pc_offset, BOUND); end
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC || fetch_fault !== BOUND || pc_offset !== 16'hCFFC)
      begin errors++; $display("FAIL top_addr: pc=%h fault=%b off=%h want fffffffc %b cffc", pc, fetch_fault, pc_offset, BOUND); end
    redirect = 0;
    tick();
    checks++; if (pc !== 32'h0 || fetch_fault !== BOUND || pc_offset !== 16'hD000)
      begin errors++; $display("FAIL wrap32: pc=%h fault=%b off=%h want 0 %b d000", pc, fetch_fault, pc_offset, BOUND); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_exception();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program counter generator that owns the PC register, the exception-return state and the fetch-address fault check. It computes the sequential next PC internally and accepts redirects, exception entry and ERET from later pipeline stages. It keeps a registered EPC and an exception-level flag. It sits at the head of the fetch stage, feeding instruction memory and the IF/ID register.

## Interface
- `WIDTH`, 32, PC/address width in bits
- `RESET_VEC`, 32'h0000_3000, PC value after reset
- `HANDLER_VEC`, 32'h0000_4180, exception handler entry address
- `ADDR_LO`, 32'h0000_3000, lowest legal fetch address (inclusive)
- `ADDR_HI`, 32'h0000_4FFC, highest legal fetch address (inclusive)
- `ALIGN_BITS`, 2, log2 of instruction size; sequential increment is 1<<ALIGN_BITS

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC (sequential and redirect updates only).
- `redirect` in 1: branch/jump taken.
- `redirect_pc` in WIDTH: branch/jump target.
- `exc_req` in 1: exception taken by a later stage.
- `exc_pc` in WIDTH: victim PC to save in EPC.
- `eret` in 1: return from exception.
- `pc` out WIDTH: current fetch PC.
- `pc_offset` out 16: `pc[15:0]` − `ADDR_LO[15:0]`, for instruction memory indexing.
- `fetch_fault` out 1: current PC is illegal.
- `fetch_exc_code` out 5: `EXC_ADEL` when `fetch_fault` is 1, else 0.
- `epc` out WIDTH: saved return address.
- `exl` out 1: exception level (1 = in handler).

## Operation
- State machine with two states, encoded by `exl`: RUN (`exl`=0) and HANDLER (`exl`=1).
- PC update priority each rising edge, highest first:
  1. `exc_req`: `pc`←`HANDLER_VEC`. If `exl`=0: `epc`←`exc_pc` and `exl`←1. If `exl`=1 (nested): `epc` and `exl` are unchanged.
  2. `eret` with `exl`=1: `pc`←`epc`, `exl`←0.
  3. `eret` with `exl`=0: ignored; falls through to the next rule.
  4. `stall`: `pc` holds.
  5. `redirect`: `pc`←`redirect_pc`.
  6. Otherwise: `pc`←`pc` + (1<<`ALIGN_BITS`), modulo 2^WIDTH.
- `exc_req` and `eret` override `stall`.
- `exc_req` beats a simultaneous `eret`.
- `redirect` under `stall` is dropped. Upstream must hold `redirect` until `stall` deasserts.
- Fault check is combinational on the `pc` register, not on any input:
  - misaligned: `pc[ALIGN_BITS-1:0]` ≠ 0.
  - out of range: `pc` < `ADDR_LO` or `pc` > `ADDR_HI`, unsigned compare.
  - `fetch_fault` = misaligned OR out-of-range.
- The block never self-traps. The pipeline carries `fetch_fault` forward and later returns it as `exc_req`.
- `epc` is written only on exception entry from RUN.

## Timing
- Reset (asynchronous, `reset`=0) forces:
  - `pc`=`RESET_VEC`, `epc`=0, `exl`=0.
  - Therefore `fetch_fault`=0 and `fetch_exc_code`=0 for default parameters.
- Release from reset is synchronised by the system. First update happens on the first rising edge with `reset`=1.
- Latency: every control input takes effect on `pc` exactly one edge later. Outputs are valid in the same cycle as the `pc` value they describe.
- Reset asserted mid-exception: `exl` clears immediately and the pending `eret` is lost.
- Wrap-around: `pc` = 2^WIDTH − 4 increments to 0, and `fetch_fault` is 1 at both values.

## Configuration
- `PC_BOUND_CHECK_EN` defined: range check active, as described above.
- Not defined:
  - Only the alignment check contributes to `fetch_fault`.
  - `ADDR_LO`/`ADDR_HI` affect only `pc_offset`.
  - The comparator logic is absent.

## Structure
- Shared package/header holds:
  - `EXC_ADEL` (5'd4) and `EXC_NONE` (5'd0).
  - Default `RESET_VEC`, `HANDLER_VEC`, `ADDR_LO`, `ADDR_HI`.
- One sub-module, `pc_fault_check`, holds the combinational alignment/range check and exception-code encode.
  - Parametrised by `WIDTH`, `ALIGN_BITS`, `ADDR_LO`, `ADDR_HI`.
  - The `PC_BOUND_CHECK_EN` guard lives inside it.

## Test plan
- Reset then 3 free-running edges → `pc` goes 0x3000, 0x3004, 0x3008, 0x300C. Mid-run `reset`=0 → `pc`=0x3000 immediately, without waiting for a clock edge.
- `stall`=1 for 2 cycles at `pc`=0x3008 → `pc` holds 0x3008. Then `redirect`=1 with `redirect_pc`=0x3100 under `stall` → held. Release `stall` → `pc`=0x3100 next edge.
- `exc_req`=1 with `exc_pc`=0x3010 and `stall`=1 → next edge: `pc`=0x4180, `epc`=0x3010, `exl`=1. Second `exc_req` with `exc_pc`=0x4184 → `epc` stays 0x3010.
- `eret` in HANDLER → `pc`=0x3010, `exl`=0. `eret` in RUN → `pc` increments normally. `exc_req` and `eret` together → handler entry wins.
- `redirect_pc`=0x3002 → `fetch_fault`=1, code 4. `redirect_pc`=0x5000 → fault=1 with `PC_BOUND_CHECK_EN`, fault=0 without it.
- `WIDTH`=16 with `RESET_VEC`=16'hFFFC → after one edge `pc`=0x0000, and `fetch_fault`=1 with the range check enabled.
